// File: rtl/sparse_index_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_index_stream_if
//  Description : Handshake bundle for sparse_index_stream. The mask producer
//                and the index consumer sit on the master side. The
//                serialiser sits on the slave side.
//                  in_valid/in_ready/in_seq    - activity mask input
//                  out_valid/out_ready         - index beat output
//                  out_addr/out_ord/out_last   - beat payload
//                  empty_pulse/busy            - status
//  Revision    : 1.0  initial release
// ============================================================================
interface sparse_index_stream_if #(
    parameter int N    = 16,
    parameter int LOGN = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_seq;
    logic            out_valid;
    logic            out_ready;
    logic [LOGN-1:0] out_addr;
    logic [LOGN:0]   out_ord;
    logic            out_last;
    logic            empty_pulse;
    logic            busy;

    modport master (
        output in_valid, in_seq, out_ready,
        input  in_ready, out_valid, out_addr, out_ord, out_last, empty_pulse, busy
    );

    modport slave (
        input  in_valid, in_seq, out_ready,
        output in_ready, out_valid, out_addr, out_ord, out_last, empty_pulse, busy
    );
endinterface
`default_nettype wire

// File: rtl/sparse_index_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_index_stream
//  Description : Serialises an N-bit channel activity mask into a stream of
//                set-bit indices, one per accepted beat. Each bit is cleared
//                as it is emitted. A new mask may be loaded on the cycle the
//                final beat of the previous one is accepted, so consecutive
//                masks stream without bubbles.
//  Ports       : clk, rst (sync, active high)
//                bus.in_valid/in_ready/in_seq     mask load handshake
//                bus.out_valid/out_ready          beat handshake
//                bus.out_addr/out_ord/out_last    beat payload
//                bus.empty_pulse                  all-zero mask was loaded
//                bus.busy                         set bits remain
//  Revision    : 1.0  initial release
// ============================================================================
module sparse_index_stream #(
    parameter int N         = 16,
    parameter int LOGN      = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    sparse_index_stream_if.slave    bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          r_state, w_state_nx;
    logic [N-1:0]    r_mask,  w_mask_nx;
    logic [LOGN:0]   r_ord,   w_ord_nx;
    logic            r_empty, w_empty_nx;

    logic [LOGN-1:0] w_addr;
    logic            w_single;
    logic            w_emit;
    logic            w_last;
    logic            w_accept;
    logic            w_in_ready;
    logic            w_load;

    // Priority search over the held mask. The last match in loop order wins,
    // so the loop runs away from the end that should take priority.
    generate
        if (MSB_FIRST) begin : g_msb_first
            always_comb begin
                w_addr = '0;
                for (int i = 0; i < N; i++) begin
                    if (r_mask[i]) w_addr = LOGN'(i);
                end
            end
        end else begin : g_lsb_first
            always_comb begin
                w_addr = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (r_mask[i]) w_addr = LOGN'(i);
                end
            end
        end
    endgenerate

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    assign w_single   = (r_mask != '0) && ((r_mask & (r_mask - N'(1))) == '0);
    assign w_emit     = (r_state == EMIT);
    assign w_last     = w_emit & w_single;
    assign w_accept   = w_emit & bus.out_ready;
    // Ready on the final accepted beat gives back-to-back reloads.
    assign w_in_ready = ~w_emit | (w_accept & w_last);
    assign w_load     = bus.in_valid & w_in_ready;

    always_comb begin
        w_state_nx = r_state;
        w_mask_nx  = r_mask;
        w_ord_nx   = r_ord;
        w_empty_nx = 1'b0;

        if (w_accept) begin
            w_mask_nx = r_mask & ~(N'(1) << w_addr);
            w_ord_nx  = r_ord + (LOGN+1)'(1);
            if (w_last) w_state_nx = IDLE;
        end

        // A load overrides the accept bookkeeping; it only coincides with
        // the final beat, whose residual mask is zero anyway.
        if (w_load) begin
            w_mask_nx  = bus.in_seq;
            w_ord_nx   = '0;
            w_state_nx = (bus.in_seq != '0) ? EMIT : IDLE;
            w_empty_nx = (bus.in_seq == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_ord   <= '0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mask  <= w_mask_nx;
            r_ord   <= w_ord_nx;
            r_empty <= w_empty_nx;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_emit;
    assign bus.out_addr    = w_addr;
    assign bus.out_ord     = r_ord;
    assign bus.out_last    = w_last;
    assign bus.empty_pulse = r_empty;
    assign bus.busy        = w_emit;
endmodule
`default_nettype wire
